pc_fetch_ctrl: RTL

Sequences the CPU's PC register and instruction fetch. It drives the select of the next-PC mux (sequential PC+4 vs. branch/jump offset target), registers the mux result as the new PC, and runs a request/acknowledge handshake with instruction memory. It hands fetched instructions to decode through a valid/ready interface. It sits between the next-PC mux, the instruction memory port and the decode stage, and absorbs variable memory latency, decode stalls and execute-stage redirects.

---
 rtl/pc_fetch_pkg.sv | 21 ++
 rtl/fetch_perf_cnt.sv | 20 ++
 rtl/pc_fetch_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [1:0]  NPC_SEL_SEQ      = 2'b00;
    localparam logic [1:0]  NPC_SEL_OFFSET   = 2'b01;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned, so every PC load drops the byte offset.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// 32-bit wrapping event counter with synchronous reset.
// Latency: count visible the cycle after the event.
// Backpressure: none; counts every cycle inc is high.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    // Count events, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 32'd0;
        end else if (inc) begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction fetch sequencer (IDLE/FETCH/HOLD); PC_FETCH_PERF_EN adds perf counters.
// Latency: imem_ack to inst_valid 1 cycle; accept to next imem_req 1 cycle.
// Backpressure: HOLD keeps inst until decode accepts without stall; memory holds off via imem_ack.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic        stall,
    input  logic [31:0] npc,
    output logic [1:0]  npc_sel,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready
`ifdef PC_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_squash_cnt
`endif
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  redir_pc, redir_pc_nxt;
    logic [31:0]  inst_nxt;
    logic         squash, squash_nxt;
    logic         accept_evt;
    logic         squash_evt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath values; redirect outranks stall and accept.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        redir_pc_nxt = redir_pc;
        squash_nxt   = squash;
        inst_nxt     = inst;
        accept_evt   = 1'b0;
        squash_evt   = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) begin
                    pc_nxt = word_align(npc);
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Same-cycle redirect is newer than any parked target.
                        pc_nxt     = word_align(npc);
                        squash_nxt = 1'b0;
                        squash_evt = 1'b1;
                    end else if (squash) begin
                        pc_nxt     = word_align(redir_pc);
                        squash_nxt = 1'b0;
                        squash_evt = 1'b1;
                    end else begin
                        inst_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until ack, so park the target.
                    redir_pc_nxt = word_align(npc);
                    squash_nxt   = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt     = word_align(npc);
                    state_nxt  = FETCH;
                    squash_evt = 1'b1;
                end else if (!stall && inst_ready) begin
                    pc_nxt     = word_align(npc);
                    state_nxt  = FETCH;
                    accept_evt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            redir_pc <= 32'd0;
            squash   <= 1'b0;
            inst     <= 32'd0;
        end else begin
            pc       <= pc_nxt;
            redir_pc <= redir_pc_nxt;
            squash   <= squash_nxt;
            inst     <= inst_nxt;
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);
    assign npc_sel    = (redirect && !rst) ? NPC_SEL_OFFSET : NPC_SEL_SEQ;

`ifdef PC_FETCH_PERF_EN
    fetch_perf_cnt u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept_evt),
        .cnt (perf_fetch_cnt)
    );

    fetch_perf_cnt u_squash_cnt (
        .clk (clk),
        .rst (rst),
        .inc (squash_evt),
        .cnt (perf_squash_cnt)
    );
`else
    logic unused_perf_evt;
    assign unused_perf_evt = accept_evt ^ squash_evt;
`endif

endmodule
